// File: rtl/text_wr_sched_if.sv
// Handshake and display-RAM write bundle for text_wr_sched.
// master = character sources / display side, slave = the scheduler.
interface text_wr_sched_if;
  logic        kb_valid;
  logic [7:0]  kb_ascii;
  logic        kb_ready;
  logic        hs_valid;
  logic [7:0]  hs_ascii;
  logic        hs_ready;
  logic        clr_req;
  logic        vm_wren;
  logic [11:0] vm_waddr;
  logic [7:0]  vm_wdata;
  logic [11:0] cursor;
  logic        busy;

  modport master (
    output kb_valid, kb_ascii, hs_valid, hs_ascii, clr_req,
    input  kb_ready, hs_ready, vm_wren, vm_waddr, vm_wdata, cursor, busy
  );

  modport slave (
    input  kb_valid, kb_ascii, hs_valid, hs_ascii, clr_req,
    output kb_ready, hs_ready, vm_wren, vm_waddr, vm_wdata, cursor, busy
  );
endinterface

// File: rtl/text_wr_sched.sv
// Write-side scheduler for the 70x30 text RAM: kb/host arbitration, control codes, full clear.
// HOST_PRIO_EN: when defined, the host stream always wins over the keyboard (no round-robin).
module text_wr_sched #(
  parameter int unsigned COLS     = 70,
  parameter int unsigned ROWS     = 30,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic            clk,
  input  logic            reset,
  text_wr_sched_if.slave  bus
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLEAR = 2'd2} state_t;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  function automatic logic [11:0] step_fwd(input logic [11:0] pos);
    logic [6:0] c;
    logic [4:0] r;
    c = pos[11:5];
    r = pos[4:0];
    if (c == LAST_COL) begin
      c = 7'd0;
      r = (r == LAST_ROW) ? 5'd0 : r + 5'd1;
    end else begin
      c = c + 7'd1;
    end
    return {c, r};
  endfunction

  function automatic logic [11:0] next_cursor(input logic [7:0] ch, input logic [11:0] pos);
    logic [11:0] n;
    n = pos;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      n = step_fwd(pos);
    end else if (ch == 8'h0D) begin
      n = {7'd0, (pos[4:0] == LAST_ROW) ? 5'd0 : pos[4:0] + 5'd1};
    end else if (ch == 8'h08) begin
      if (pos[11:5] != 7'd0) begin
        n = {pos[11:5] - 7'd1, pos[4:0]};
      end else if (pos[4:0] != 5'd0) begin
        n = {LAST_COL, pos[4:0] - 5'd1};
      end else begin
        n = pos;
      end
    end else begin
      n = pos;
    end
    return n;
  endfunction

  // Backspace writes at the cell it moves onto; printables write at the current cell.
  function automatic wr_t write_for(input logic [7:0] ch, input logic [11:0] pos);
    wr_t w;
    w.wr   = 1'b0;
    w.addr = pos;
    w.data = ch;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      w.wr = 1'b1;
    end else if (ch == 8'h08 && pos != 12'd0) begin
      w.wr   = 1'b1;
      w.addr = next_cursor(ch, pos);
      w.data = CLR_CHAR;
    end else begin
      w.wr = 1'b0;
    end
    return w;
  endfunction

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  char_q, char_d;
  logic [11:0] cursor_q, cursor_d;
  logic        wren_q, wren_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
`ifdef HOST_PRIO_EN
`else
  logic        pref_hs_q, pref_hs_d;
`endif

  logic        idle_free_s;
  logic        pick_hs_s;
  logic        kb_grant_s;
  logic        hs_grant_s;
  logic [7:0]  sel_char_s;
  wr_t         grant_wr_s;

  // Source selection and combinational ready
  always_comb begin
    idle_free_s = (state_q == IDLE) && !pend_q;
`ifdef HOST_PRIO_EN
    pick_hs_s   = bus.hs_valid;
`else
    pick_hs_s   = bus.hs_valid && (!bus.kb_valid || pref_hs_q);
`endif
    kb_grant_s  = idle_free_s && bus.kb_valid && !pick_hs_s;
    hs_grant_s  = idle_free_s && pick_hs_s;
    sel_char_s  = pick_hs_s ? bus.hs_ascii : bus.kb_ascii;
    grant_wr_s  = write_for(sel_char_s, cursor_q);
  end

  // Next-state, write-port and cursor logic
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | bus.clr_req;
    char_d    = char_q;
    cursor_d  = cursor_q;
    wren_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
`ifdef HOST_PRIO_EN
`else
    pref_hs_d = pref_hs_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = CLEAR;
          pend_d  = bus.clr_req;
          wren_d  = 1'b1;
          waddr_d = 12'd0;
          wdata_d = CLR_CHAR;
        end else if (kb_grant_s || hs_grant_s) begin
          state_d = EXEC;
          char_d  = sel_char_s;
          wren_d  = grant_wr_s.wr;
          waddr_d = grant_wr_s.addr;
          wdata_d = grant_wr_s.data;
`ifdef HOST_PRIO_EN
`else
          pref_hs_d = !pick_hs_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d  = IDLE;
        cursor_d = next_cursor(char_q, cursor_q);
      end
      CLEAR: begin
        // The cell on the bus this cycle is the one just issued; stop after the last one.
        if (waddr_q == {LAST_COL, LAST_ROW}) begin
          state_d  = IDLE;
          cursor_d = 12'd0;
          wren_d   = 1'b0;
        end else begin
          wren_d   = 1'b1;
          waddr_d  = step_fwd(waddr_q);
          wdata_d  = CLR_CHAR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      char_q    <= 8'd0;
      cursor_q  <= 12'd0;
      wren_q    <= 1'b0;
      waddr_q   <= 12'd0;
      wdata_q   <= 8'd0;
`ifdef HOST_PRIO_EN
`else
      pref_hs_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      char_q    <= char_d;
      cursor_q  <= cursor_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef HOST_PRIO_EN
`else
      pref_hs_q <= pref_hs_d;
`endif
    end
  end

  assign bus.kb_ready = kb_grant_s;
  assign bus.hs_ready = hs_grant_s;
  assign bus.vm_wren  = wren_q;
  assign bus.vm_waddr = waddr_q;
  assign bus.vm_wdata = wdata_q;
  assign bus.cursor   = cursor_q;
  assign bus.busy     = (state_q != IDLE) | pend_q;

endmodule

// File: doc/text_wr_sched.md
Name: text_wr_sched

Overview:
- Write-side controller for the 70x30 character display RAM.
- Owns the single write port (wraddress/data/wren) and the cursor position.
- Arbitrates two character sources: keyboard stream (kb) and host/result printer stream (hs, e.g. digest output).
- Decodes control codes and sequences a full-screen clear.
- Cursor output feeds the display path for cursor-blink comparison against the read address.

Parameters:
COLS, 70, characters per row; column counter range 0..COLS-1, 7 bits
ROWS, 30, rows per screen; row counter range 0..ROWS-1, 5 bits
CLR_CHAR, 8'h20, character written to every cell during clear and by backspace

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
kb_valid  in  1  keyboard has a character
kb_ascii  in  8  keyboard character
kb_ready  out  1  keyboard character accepted this cycle
hs_valid  in  1  host stream has a character
hs_ascii  in  8  host character
hs_ready  out  1  host character accepted this cycle
clr_req  in  1  single-cycle clear-screen request
vm_wren  out  1  display RAM write enable
vm_waddr  out  12  RAM address {col[6:0], row[4:0]}
vm_wdata  out  8  RAM write data
cursor  out  12  current cursor {col, row}, same format as vm_waddr
busy  out  1  high in EXEC or CLEAR, or while a clear is pending

Behaviour:
- Reset, asynchronous and active-high. Forces the following:
  - state=IDLE;
  - all outputs 0 (cursor={0,0});
  - clear-pending flag 0;
  - round-robin pointer = kb preferred.
  - Reset mid-clear aborts immediately; no further writes occur.
- clr_req latches into a sticky pending flag in any state. The flag is cleared on entry to CLEAR.
- States: IDLE, EXEC, CLEAR.
- IDLE:
  - Clear pending -> CLEAR. Pending clear has highest priority; no ready is asserted that cycle.
  - Else if exactly one of kb_valid/hs_valid is high -> grant it.
  - Else if both are high -> grant the non-preferred-last source (round-robin). The pointer toggles to the other source after each grant.
  - Grant: the matching *_ready is high for exactly that cycle (combinational from state/valid/pointer). The character is latched and the state goes to EXEC.
  - Ready is never high in EXEC or CLEAR. At most one ready is high per cycle.
- EXEC: one cycle, then back to IDLE. Throughput is 1 char per 2 cycles. The action depends on the latched character:
  - Printable 0x20..0x7E:
    - vm_wren=1, vm_waddr=cursor, vm_wdata=char.
    - Cursor advances col+1.
    - At col COLS-1: col=0, row+1.
    - At row ROWS-1: row=0 (wrap to top, no scroll).
  - 0x0D (CR): no write; col=0, row+1 with the same row wrap.
  - 0x08 (BS):
    - If col>0: col-1 and write CLR_CHAR at the new position.
    - If col=0, row>0: move to {COLS-1, row-1} and write CLR_CHAR there.
    - At {0,0}: no move, no write.
  - Any other code: accepted and discarded; no write, cursor unchanged.
- Write timing: vm_wren/vm_waddr/vm_wdata are registered and valid in the EXEC cycle, i.e. the cycle after the handshake. vm_wren is otherwise 0.
- cursor updates on the clock edge ending EXEC.
- CLEAR:
  - Walks every cell, writing CLR_CHAR one per cycle.
  - Order: row-major, row 0..ROWS-1, col 0..COLS-1 within each row.
  - vm_wren=1 for exactly COLS*ROWS = 2100 consecutive cycles.
  - On the last cell: cursor={0,0}, state goes to IDLE.
  - clr_req arriving during CLEAR re-arms pending, so one more full clear follows.
- busy = (state!=IDLE) | pending.

Optional Feature:
HOST_PRIO_EN
- Defined: fixed priority, hs always wins when both sources are valid; the round-robin pointer is removed.
- Undefined: round-robin as described above.
- Clear priority is unchanged in both builds.

Test Plan:
- Reset, then kb sends 'A'(0x41) -> kb_ready 1 cycle; next cycle vm_wren=1, vm_waddr=0x000, vm_wdata=0x41; cursor becomes {1,0} = 0x020.
- Cursor at {69,29}, send 'Z' -> write at {69,29}; cursor wraps to {0,0}. From {5,3}, send CR -> no vm_wren; cursor {0,4}.
- Backspace: from {0,2} -> write 0x20 at {69,1}, cursor {69,1}. From {0,0} -> no write, cursor stays {0,0}.
- kb_valid and hs_valid both held high with distinct chars -> grants alternate kb,hs,kb,hs (hs,hs,... with HOST_PRIO_EN); never both ready in one cycle.
- Pulse clr_req while a char is pending -> 2100 consecutive vm_wren writes of 0x20, first {0,0}, last {69,29}; ready low throughout; cursor 0 at end; then the queued char is served.
- Assert reset at clear write #500 -> vm_wren drops asynchronously, busy 0, cursor 0.
